// File: rtl/ntt_obi_slave_responder_if.sv
// OBI request/response bundle between the X-HEEP external crossbar port
// and the NTT accelerator slave responder.
//   req/we/be/addr/wdata : request channel, driven by the master
//   gnt                  : grant, driven by the slave (combinational)
//   rvalid/rdata         : response channel, driven by the slave
interface ntt_obi_slave_responder_if;
  logic        req;
  logic        we;
  logic [3:0]  be;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        gnt;
  logic        rvalid;
  logic [31:0] rdata;

  modport master (
    output req, we, be, addr, wdata,
    input  gnt, rvalid, rdata
  );

  modport slave (
    input  req, we, be, addr, wdata,
    output gnt, rvalid, rdata
  );
endinterface

// File: rtl/ntt_obi_slave_responder.sv
// OBI slave responder for the NTT/INTT coefficient memory window.
// Decodes window offsets, forwards in-memory accesses to the coefficient
// SRAM, answers out-of-memory accesses locally with an error pattern, and
// returns exactly one in-order response per grant one cycle later.
// Bus access is stalled while the NTT core owns the SRAM.
//
// Ports:
//   clk_i, rst_i        : clock, synchronous active-high reset
//   bus (slave modport) : OBI request/grant/response
//   mem_*               : coefficient SRAM request port (word indexed)
//   core_busy_i         : NTT core owns the SRAM
//   rd/wr/err_cnt_o     : saturating grant statistics
//   err_o               : sticky out-of-memory flag
//
// state  | meaning
// OPEN   | serving bus requests
// LOCKED | core owns SRAM, no grants, no SRAM requests
// DRAIN  | one stall cycle after core release so its last SRAM response retires
module ntt_obi_slave_responder #(
  parameter logic [31:0] START_ADDR  = 32'hF000_0000,
  parameter logic [31:0] WINDOW_SIZE = 32'h0020_0000,
  parameter int          MEM_DEPTH   = 512,
  parameter logic [31:0] ERR_RDATA   = 32'hDEAD_BEEF
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  ntt_obi_slave_responder_if.slave     bus,
  output logic                         mem_req_o,
  output logic                         mem_we_o,
  output logic [3:0]                   mem_be_o,
  output logic [$clog2(MEM_DEPTH)-1:0] mem_addr_o,
  output logic [31:0]                  mem_wdata_o,
  input  logic                         mem_gnt_i,
  input  logic [31:0]                  mem_rdata_i,
  input  logic                         core_busy_i,
  output logic [15:0]                  rd_cnt_o,
  output logic [15:0]                  wr_cnt_o,
  output logic [15:0]                  err_cnt_o,
  output logic                         err_o
);

  localparam int          AW        = $clog2(MEM_DEPTH);
  localparam logic [31:0] MEM_BYTES = 32'(MEM_DEPTH * 4);

  typedef enum logic [1:0] {
    OPEN   = 2'd0,
    LOCKED = 2'd1,
    DRAIN  = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] offset;
  logic        in_mem;
  logic        gnt;
  logic        rvalid_q;
  logic        rsp_mem_rd_q;
  logic        rsp_err_rd_q;
  logic [15:0] rd_cnt_q, wr_cnt_q, err_cnt_q;
  logic        err_q;

  // Addresses below START_ADDR wrap to huge offsets and fail both compares.
  assign offset = bus.addr - START_ADDR;
  assign in_mem = (offset < WINDOW_SIZE) && (offset < MEM_BYTES);

  assign mem_addr_o  = offset[AW+1:2];
  assign mem_we_o    = bus.we;
  assign mem_be_o    = bus.be;
  assign mem_wdata_o = bus.wdata;

  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= OPEN;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    gnt       = 1'b0;
    mem_req_o = 1'b0;
    case (state_q)
      OPEN: begin
        if (!rst_i) begin
          mem_req_o = bus.req & in_mem;
          gnt       = bus.req & (in_mem ? mem_gnt_i : 1'b1);
        end
        if (core_busy_i) state_d = LOCKED;
      end
      LOCKED: begin
        if (!core_busy_i) state_d = DRAIN;
      end
      DRAIN: begin
        state_d = OPEN;
      end
      default: begin
        state_d = OPEN;
      end
    endcase
  end

  assign bus.gnt = gnt;

  // Response select is captured with the grant; read data itself comes
  // straight from the SRAM in the response cycle.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rvalid_q     <= 1'b0;
      rsp_mem_rd_q <= 1'b0;
      rsp_err_rd_q <= 1'b0;
    end else begin
      rvalid_q     <= gnt;
      rsp_mem_rd_q <= gnt & ~bus.we & in_mem;
      rsp_err_rd_q <= gnt & ~bus.we & ~in_mem;
    end
  end

  assign bus.rvalid = rvalid_q;

  always_comb begin
    bus.rdata = '0;
    if (rvalid_q) begin
      if (rsp_mem_rd_q)      bus.rdata = mem_rdata_i;
      else if (rsp_err_rd_q) bus.rdata = ERR_RDATA;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rd_cnt_q  <= '0;
      wr_cnt_q  <= '0;
      err_cnt_q <= '0;
      err_q     <= 1'b0;
    end else if (gnt) begin
      if (!in_mem) begin
        err_q <= 1'b1;
        if (err_cnt_q != 16'hFFFF) err_cnt_q <= err_cnt_q + 16'd1;
      end else if (bus.we) begin
        if (wr_cnt_q != 16'hFFFF) wr_cnt_q <= wr_cnt_q + 16'd1;
      end else begin
        if (rd_cnt_q != 16'hFFFF) rd_cnt_q <= rd_cnt_q + 16'd1;
      end
    end
  end

  assign rd_cnt_o  = rd_cnt_q;
  assign wr_cnt_o  = wr_cnt_q;
  assign err_cnt_o = err_cnt_q;
  assign err_o     = err_q;

endmodule

// File: tb/tb_ntt_obi_slave_responder.sv
module tb_ntt_obi_slave_responder;
  localparam logic [31:0] S = 32'hF000_0000;

  logic        clk;
  logic        rst;
  logic        mem_req, mem_we, mem_gnt, core_busy, err;
  logic [3:0]  mem_be;
  logic [8:0]  mem_addr;
  logic [31:0] mem_wdata, mem_rdata;
  logic [15:0] rd_cnt, wr_cnt, err_cnt;
  int          total = 0;
  int          bad   = 0;

  ntt_obi_slave_responder_if bus ();

  ntt_obi_slave_responder dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .bus         (bus.slave),
    .mem_req_o   (mem_req),
    .mem_we_o    (mem_we),
    .mem_be_o    (mem_be),
    .mem_addr_o  (mem_addr),
    .mem_wdata_o (mem_wdata),
    .mem_gnt_i   (mem_gnt),
    .mem_rdata_i (mem_rdata),
    .core_busy_i (core_busy),
    .rd_cnt_o    (rd_cnt),
    .wr_cnt_o    (wr_cnt),
    .err_cnt_o   (err_cnt),
    .err_o       (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic req, input logic we, input logic [31:0] addr,
                       input logic [31:0] wdata);
    bus.req   = req;
    bus.we    = we;
    bus.be    = 4'hF;
    bus.addr  = addr;
    bus.wdata = wdata;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 32'h0, 32'h0);
  endtask

  initial begin
    rst = 1'b1; mem_gnt = 1'b1; core_busy = 1'b0; mem_rdata = '0;
    idle();

    // reset: grant and SRAM request blocked even with a valid request
    @(negedge clk); drive(1'b1, 1'b0, S, 32'h0); #1;
    chk("rst_gnt", bus.gnt, 0);
    chk("rst_mreq", mem_req, 0);
    @(negedge clk); rst = 1'b0; idle(); #1;
    chk("rst_rvalid", bus.rvalid, 0);
    chk("rst_rdata", bus.rdata, 0);
    chk("rst_rdcnt", rd_cnt, 0);
    chk("rst_wrcnt", wr_cnt, 0);
    chk("rst_errcnt", err_cnt, 0);
    chk("rst_err", err, 0);

    // basic write
    @(negedge clk); drive(1'b1, 1'b1, S + 32'h8, 32'h0000_0ABC); #1;
    chk("wr_gnt", bus.gnt, 1);
    chk("wr_mreq", mem_req, 1);
    chk("wr_mwe", mem_we, 1);
    chk("wr_maddr", mem_addr, 2);
    chk("wr_mbe", mem_be, 4'hF);
    chk("wr_mwdata", mem_wdata, 32'h0000_0ABC);
    @(negedge clk); idle(); #1;
    chk("wr_rvalid", bus.rvalid, 1);
    chk("wr_rdata", bus.rdata, 0);
    chk("wr_cnt1", wr_cnt, 1);

    // basic read back
    @(negedge clk); drive(1'b1, 1'b0, S + 32'h8, 32'h0); #1;
    chk("rd_gnt", bus.gnt, 1);
    chk("rd_mreq", mem_req, 1);
    chk("rd_mwe", mem_we, 0);
    chk("rd_maddr", mem_addr, 2);
    @(negedge clk); idle(); mem_rdata = 32'h0000_0ABC; #1;
    chk("rd_rvalid", bus.rvalid, 1);
    chk("rd_rdata", bus.rdata, 32'h0000_0ABC);
    chk("rd_cnt1", rd_cnt, 1);

    // four back-to-back reads
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (i < 4) drive(1'b1, 1'b0, S + 32'(4 * i), 32'h0);
      else idle();
      mem_rdata = 32'h100 + 32'(i) - 32'h1;
      #1;
      if (i < 4) begin
        chk("pipe_gnt", bus.gnt, 1);
        chk("pipe_maddr", mem_addr, 32'(i));
      end
      if (i > 0) begin
        chk("pipe_rvalid", bus.rvalid, 1);
        chk("pipe_rdata", bus.rdata, 32'h100 + 32'(i) - 32'h1);
      end
    end
    @(negedge clk); idle(); mem_rdata = 32'h55; #1;
    chk("pipe_end_rvalid", bus.rvalid, 0);
    chk("pipe_end_rdata", bus.rdata, 0);
    chk("pipe_rdcnt", rd_cnt, 5);

    // last word of memory is still in range
    @(negedge clk); drive(1'b1, 1'b0, S + 32'h7FC, 32'h0); #1;
    chk("last_gnt", bus.gnt, 1);
    chk("last_mreq", mem_req, 1);
    chk("last_maddr", mem_addr, 511);
    @(negedge clk); idle(); mem_rdata = 32'hCAFE; #1;
    chk("last_rdata", bus.rdata, 32'hCAFE);
    chk("last_rdcnt", rd_cnt, 6);

    // first word past memory: read then write
    @(negedge clk); drive(1'b1, 1'b0, S + 32'h800, 32'h0); #1;
    chk("erd_gnt", bus.gnt, 1);
    chk("erd_mreq", mem_req, 0);
    @(negedge clk); drive(1'b1, 1'b1, S + 32'h800, 32'h1234); mem_rdata = 32'h1111; #1;
    chk("erd_rvalid", bus.rvalid, 1);
    chk("erd_rdata", bus.rdata, 32'hDEAD_BEEF);
    chk("erd_err", err, 1);
    chk("erd_errcnt", err_cnt, 1);
    chk("erd_rdcnt", rd_cnt, 6);
    chk("ewr_gnt", bus.gnt, 1);
    chk("ewr_mreq", mem_req, 0);
    // address below the window base
    @(negedge clk); drive(1'b1, 1'b0, S - 32'h4, 32'h0); #1;
    chk("ewr_rvalid", bus.rvalid, 1);
    chk("ewr_rdata", bus.rdata, 0);
    chk("ewr_errcnt", err_cnt, 2);
    chk("ewr_wrcnt", wr_cnt, 1);
    chk("ewr_rdcnt", rd_cnt, 6);
    chk("elo_gnt", bus.gnt, 1);
    chk("elo_mreq", mem_req, 0);
    @(negedge clk); idle(); #1;
    chk("elo_rdata", bus.rdata, 32'hDEAD_BEEF);
    chk("elo_errcnt", err_cnt, 3);
    chk("elo_rdcnt", rd_cnt, 6);

    // SRAM backpressure
    mem_gnt = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); drive(1'b1, 1'b0, S + 32'h20, 32'h0); mem_rdata = 32'h999; #1;
      chk("bp_gnt", bus.gnt, 0);
      chk("bp_mreq", mem_req, 1);
      chk("bp_rvalid", bus.rvalid, 0);
    end
    @(negedge clk); mem_gnt = 1'b1; #1;
    chk("bp_gnt_rel", bus.gnt, 1);
    chk("bp_rvalid_rel", bus.rvalid, 0);
    @(negedge clk); idle(); mem_rdata = 32'h20; #1;
    chk("bp_rsp_rvalid", bus.rvalid, 1);
    chk("bp_rsp_rdata", bus.rdata, 32'h20);
    chk("bp_rdcnt", rd_cnt, 7);

    // core lock: busy rises with a request still granted that cycle
    @(negedge clk); core_busy = 1'b1; drive(1'b1, 1'b0, S + 32'hC, 32'h0); #1;
    chk("lk_first_gnt", bus.gnt, 1);
    chk("lk_first_mreq", mem_req, 1);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk); drive(1'b1, 1'b0, S + 32'h10, 32'h0); mem_rdata = 32'h77; #1;
      chk("lk_gnt", bus.gnt, 0);
      chk("lk_mreq", mem_req, 0);
      chk("lk_rvalid", bus.rvalid, (k == 0) ? 32'h1 : 32'h0);
      if (k == 0) chk("lk_rdata", bus.rdata, 32'h77);
    end
    @(negedge clk); core_busy = 1'b0; #1;
    chk("lk_fall_gnt", bus.gnt, 0);
    chk("lk_fall_mreq", mem_req, 0);
    @(negedge clk); #1;
    chk("lk_drain_gnt", bus.gnt, 0);
    chk("lk_drain_mreq", mem_req, 0);
    @(negedge clk); #1;
    chk("lk_open_gnt", bus.gnt, 1);
    chk("lk_open_mreq", mem_req, 1);
    chk("lk_open_maddr", mem_addr, 4);
    @(negedge clk); idle(); mem_rdata = 32'h88; #1;
    chk("lk_rsp_rdata", bus.rdata, 32'h88);
    chk("lk_rdcnt", rd_cnt, 9);

    // read counter saturation
    @(negedge clk); drive(1'b1, 1'b0, S, 32'h0);
    repeat (65540) @(negedge clk);
    idle(); #1;
    chk("sat_rdcnt", rd_cnt, 16'hFFFF);
    chk("sat_wrcnt", wr_cnt, 1);
    @(negedge clk); #1;
    chk("sat_hold", rd_cnt, 16'hFFFF);

    // reset the cycle after a grant
    @(negedge clk); drive(1'b1, 1'b1, S, 32'h5); #1;
    chk("mrst_gnt", bus.gnt, 1);
    @(negedge clk); rst = 1'b1; drive(1'b1, 1'b0, S, 32'h0); #1;
    chk("mrst_pend_rvalid", bus.rvalid, 1);
    chk("mrst_gnt_forced", bus.gnt, 0);
    chk("mrst_mreq_forced", mem_req, 0);
    @(negedge clk); rst = 1'b0; idle(); #1;
    chk("mrst_rvalid", bus.rvalid, 0);
    chk("mrst_rdata", bus.rdata, 0);
    chk("mrst_rdcnt", rd_cnt, 0);
    chk("mrst_wrcnt", wr_cnt, 0);
    chk("mrst_errcnt", err_cnt, 0);
    chk("mrst_err", err, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
